// File: rtl/scoreboard_pkg.sv
`default_nettype none
// scoreboard_pkg (rev 1.0): state encoding, blank digit code and digit-count
// helper shared by the score display BCD path.
package scoreboard_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CONV = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam logic [3:0] BCD_BLANK = 4'hF;

   // Decimal digits needed for 2^bin_w-1 (302/1000 approximates log10(2)).
   function automatic int full_digits(input int bin_w);
      return (bin_w * 302) / 1000 + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// bcd_add3 (rev 1.0): one double-dabble correction cell, adds 3 to a BCD digit
// of 5 or more so the following left shift carries into the next digit.
module bcd_add3 (
   input  logic [3:0] digit,
   output logic [3:0] adjusted
);

   assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// bin_to_bcd_seq (rev 1.0): sequential shift-and-add-3 binary to BCD converter
// with start handshake, done pulse and saturation; BIN_TO_BCD_SEQ_BLANK_EN adds leading-zero blanking.
module bin_to_bcd_seq
   import scoreboard_pkg::*;
#(
   parameter int BIN_W  = 7,
   parameter int DIGITS = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [BIN_W-1:0]      bin_i,
   output logic                  ready_o,
   output logic                  valid_o,
   output logic [4*DIGITS-1:0]   bcd_o,
   output logic                  ovf_o
);

   localparam int FULL_DIGITS = full_digits(BIN_W);
   localparam int PAD_DIGITS  = (DIGITS > FULL_DIGITS) ? DIGITS : FULL_DIGITS;
   localparam int CNT_W       = $clog2(BIN_W + 1);
   localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);

   state_t                   state;
   logic [BIN_W-1:0]         bin_reg;
   logic [4*FULL_DIGITS-1:0] bcd_reg;
   logic [4*FULL_DIGITS-1:0] bcd_adj;
   logic [CNT_W-1:0]         count;
   logic [4*PAD_DIGITS-1:0]  bcd_wide;
   logic                     ovf_next;
   logic [4*DIGITS-1:0]      bcd_next;
`ifdef BIN_TO_BCD_SEQ_BLANK_EN
   logic                     blank_run;
`endif

   for (genvar k = 0; k < FULL_DIGITS; k++) begin : g_add3
      bcd_add3 u_add3 (
         .digit    (bcd_reg[4*k +: 4]),
         .adjusted (bcd_adj[4*k +: 4])
      );
   end

   // Zero-extend to cover DIGITS wider than the converter; only digits above
   // the presented range can signal overflow.
   always_comb begin
      bcd_wide = '0;
      bcd_wide[4*FULL_DIGITS-1:0] = bcd_reg;
      ovf_next = 1'b0;
      for (int k = DIGITS; k < PAD_DIGITS; k++) begin
         if (bcd_wide[4*k +: 4] != 4'd0) ovf_next = 1'b1;
      end
   end

   always_comb begin
      bcd_next = ovf_next ? {DIGITS{4'h9}} : bcd_wide[4*DIGITS-1:0];
`ifdef BIN_TO_BCD_SEQ_BLANK_EN
      blank_run = !ovf_next;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         if (blank_run && (bcd_next[4*k +: 4] == 4'd0)) bcd_next[4*k +: 4] = BCD_BLANK;
         else blank_run = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state   <= IDLE;
         bin_reg <= '0;
         bcd_reg <= '0;
         count   <= '0;
         bcd_o   <= '0;
         ovf_o   <= 1'b0;
         valid_o <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  bin_reg <= bin_i;
                  bcd_reg <= '0;
                  count   <= '0;
                  state   <= CONV;
               end
            end
            CONV: begin
               bcd_reg <= (bcd_adj << 1) | {{(4*FULL_DIGITS-1){1'b0}}, bin_reg[BIN_W-1]};
               bin_reg <= bin_reg << 1;
               count   <= count + 1'b1;
               if (count == LAST_SHIFT) state <= DONE;
            end
            DONE: begin
               ovf_o   <= ovf_next;
               bcd_o   <= bcd_next;
               valid_o <= 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign ready_o = (state == IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// tb_bin_to_bcd_seq (rev 1.0): scoreboard bench for the default converter plus
// two 16-bit instances covering wide output and overflow saturation.
module tb_bin_to_bcd_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // default instance (7 bits, 2 digits)
   logic        start = 1'b0;
   logic [6:0]  bin = '0;
   logic        ready, valid, ovf;
   logic [7:0]  bcd;

   // 16-bit instances share stimulus
   logic        start16 = 1'b0;
   logic [15:0] bin16 = '0;
   logic        r5, v5, o5, r3, v3, o3;
   logic [19:0] bcd5;
   logic [11:0] bcd3;

   bin_to_bcd_seq #(.BIN_W(7), .DIGITS(2)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .bin_i(bin),
      .ready_o(ready), .valid_o(valid), .bcd_o(bcd), .ovf_o(ovf)
   );

   bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut5 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start16), .bin_i(bin16),
      .ready_o(r5), .valid_o(v5), .bcd_o(bcd5), .ovf_o(o5)
   );

   bin_to_bcd_seq #(.BIN_W(16), .DIGITS(3)) dut3 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start16), .bin_i(bin16),
      .ready_o(r3), .valid_o(v3), .bcd_o(bcd3), .ovf_o(o3)
   );

   int checks = 0;
   int errors = 0;
   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0]  bcd;
      logic        ovf;
      int unsigned due;
   } exp_t;
   exp_t q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference by repeated division: returns {ovf, bcd[39:0]}.
   function automatic logic [40:0] model(input int unsigned v, input int digits);
      logic [39:0] b = '0;
      int unsigned t = v;
      logic        o;
      bit          run = 1'b1;
      for (int k = 0; k < digits; k++) begin
         b[4*k +: 4] = 4'(t % 10);
         t = t / 10;
      end
      o = (t != 0);
      if (o) begin
         b = '0;
         for (int k = 0; k < digits; k++) b[4*k +: 4] = 4'h9;
      end
`ifdef BIN_TO_BCD_SEQ_BLANK_EN
      if (!o) begin
         for (int k = digits - 1; k >= 1; k--) begin
            if (run && b[4*k +: 4] == 4'h0) b[4*k +: 4] = 4'hF;
            else run = 1'b0;
         end
      end
`endif
      return {o, b};
   endfunction

   // Called at the negedge before the accepting edge.
   task automatic push(input int unsigned v, input int unsigned now);
      logic [40:0] m;
      exp_t e;
      m = model(v, 2);
      e.bcd = m[7:0];
      e.ovf = m[40];
      e.due = now + 9;
      q.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && valid) begin
         if (q.size() == 0) begin
            check("spurious_valid", valid, 1'b0);
         end else begin
            e = q.pop_front();
            check("bcd", bcd, e.bcd);
            check("ovf", ovf, e.ovf);
            check("latency_cyc", cyc, e.due);
         end
      end
   end

   task automatic convert(input int unsigned v);
      int n = 0;
      @(negedge clk);
      while (!ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("ready_before_start", ready, 1'b1);
      bin = 7'(v);
      start = 1'b1;
      push(v, cyc);
      @(negedge clk);
      start = 1'b0;
      bin = 7'(~v);
   endtask

   task automatic drain();
      int n = 0;
      while (n < 60) begin
         @(negedge clk);
         #1;
         if (q.size() == 0 && ready) break;
         n++;
      end
      check("drain", (q.size() == 0) && ready, 1'b1);
   endtask

   task automatic conv16(input int unsigned v, output int unsigned lat);
      int unsigned t0;
      int n = 0;
      @(negedge clk);
      while (!r5 && n < 40) begin
         @(negedge clk);
         n++;
      end
      bin16 = 16'(v);
      start16 = 1'b1;
      t0 = cyc;
      @(negedge clk);
      start16 = 1'b0;
      n = 0;
      while (!v5 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("valid16_seen", v5, 1'b1);
      check("valid3_with_5", v3, 1'b1);
      lat = cyc - (t0 + 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned lat;
      int accepts;
      logic [40:0] m;

      repeat (2) @(negedge clk);
      check("rst_ready", ready, 1'b1);
      check("rst_valid", valid, 1'b0);
      check("rst_bcd", bcd, 8'h00);
      check("rst_ovf", ovf, 1'b0);
      rst_n = 1'b1;

      // directed values: top of range, saturation, zero, small and boundary
      convert(99);   drain();
      convert(127);  drain();
      convert(0);    drain();
      convert(100);  drain();
      convert(9);    drain();
      convert(10);   drain();

      // start held high with bin changing every cycle
      accepts = 0;
      @(negedge clk);
      start = 1'b1;
      for (int i = 0; i < 27; i++) begin
         bin = 7'($urandom_range(0, 127));
         if (ready) begin
            push(bin, cyc);
            accepts++;
         end
         @(negedge clk);
      end
      start = 1'b0;
      check("held_accepts", accepts, 3);
      drain();

      // reset at shift 3 of a conversion; previous result is nonzero
      convert(127); drain();
      @(negedge clk);
      bin = 7'd45;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_bcd", bcd, 8'h00);
      check("async_rst_ovf", ovf, 1'b0);
      check("async_rst_valid", valid, 1'b0);
      check("async_rst_ready", ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      convert(45); drain();

      // exhaustive sweep
      for (int v = 0; v < 128; v++) begin
         convert(v);
         drain();
      end

      // wide instances
      conv16(65535, lat);
      check("lat16", lat, 17);
      m = model(65535, 5);
      check("w5_bcd_65535", bcd5, m[19:0]);
      check("w5_ovf_65535", o5, 1'b0);
      check("w3_bcd_65535", bcd3, 12'h999);
      check("w3_ovf_65535", o3, 1'b1);

      conv16(1000, lat);
      m = model(1000, 5);
      check("w5_bcd_1000", bcd5, m[19:0]);
      check("w5_ovf_1000", o5, 1'b0);
      check("w3_bcd_1000", bcd3, 12'h999);
      check("w3_ovf_1000", o3, 1'b1);

      conv16(999, lat);
      check("w3_bcd_999", bcd3, 12'h999);
      check("w3_ovf_999", o3, 1'b0);

      repeat (3) @(negedge clk);
      check("queue_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
